// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the multi-port register file.
package regfile_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_NUM_RD = 2;

   typedef enum logic {
      RF_CLEAR,
      RF_READY
   } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read lane: busy mask, hardwired zero, write bypass, array mux.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic              busy_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] rf_i [2**ADDR_W],
   output logic [DATA_W-1:0] rd_data_c_o
);

   // Priority: sweep mask, then r0, then same-cycle write, then storage.
   always_comb begin
      rd_data_c_o = rf_i[rd_addr_i];
      if (busy_i) begin
         rd_data_c_o = '0;
      end else if (ZERO_REG && (rd_addr_i == '0)) begin
         rd_data_c_o = '0;
      end else if (BYPASS && wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_c_o = wr_data_i;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NUM_RD read lanes, one write port and a
// hardware clear sweep after every synchronous reset.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = RF_DATA_W,
   parameter int unsigned ADDR_W   = RF_ADDR_W,
   parameter int unsigned NUM_RD   = RF_NUM_RD,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     busy
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   rf_state_t          state_q, state_d;
   logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic               busy_d;
   logic               clr_we;
   logic               usr_we;
   logic [DATA_W-1:0]  rf_q [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= RF_CLEAR;
         clr_cnt_q <= '0;
         busy      <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy      <= busy_d;
      end
   end

   // Sweep one entry per edge; user writes only once the sweep is done.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy;
      clr_we    = 1'b0;
      usr_we    = 1'b0;
      case (state_q)
         RF_CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + CNT_W'(1);
            if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
               state_d = RF_READY;
               busy_d  = 1'b0;
            end
         end
         RF_READY: begin
            usr_we = wr_en && !(ZERO_REG && (wr_addr == '0));
         end
         default: begin
            state_d = RF_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (clr_we) begin
            rf_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
         end else if (usr_we) begin
            rf_q[wr_addr] <= wr_data;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .busy_i      (busy),
         .rd_addr_i   (rd_addr[gi*ADDR_W +: ADDR_W]),
         .wr_en_i     (wr_en),
         .wr_addr_i   (wr_addr),
         .wr_data_i   (wr_data),
         .rf_i        (rf_q),
         .rd_data_c_o (rd_data[gi*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port bypass/zero-reg build and a 2-port plain build
// driven by shared stimulus and compared against an array-based reference.
module tb_regfile_mp;

   localparam int unsigned DEPTH = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [31:0]  wr_data;
   logic [19:0]  rd_addr4;
   logic [127:0] rd_data4;
   logic [63:0]  rd_data2;
   logic         busy4;
   logic         busy2;

   always #5 clock = ~clock;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_a (
      .clock   (clock),
      .reset   (reset),
      .rd_addr (rd_addr4),
      .rd_data (rd_data4),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy4)
   );

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_b (
      .clock   (clock),
      .reset   (reset),
      .rd_addr (rd_addr4[9:0]),
      .rd_data (rd_data2),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy2)
   );

   // Reference: contents of each build, busy flag and edges left in the sweep.
   logic [31:0] mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   bit          m_busy;
   int          m_left;
   bit          m_known = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   logic         s_busy;
   logic [127:0] s_rd4;
   logic [63:0]  s_rd2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input bit is_a, input logic [4:0] a);
      if (m_busy) return 32'h0;
      if (is_a) begin
         if (a == 5'd0) return 32'h0;
         if (wr_en && (wr_addr == a)) return wr_data;
         return mem_a[a];
      end
      return mem_b[a];
   endfunction

   function automatic logic [19:0] pack(input int a0, input int a1, input int a2, input int a3);
      return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_busy  = 1'b1;
         m_left  = DEPTH;
         m_known = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
         end
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) m_busy = 1'b0;
      end else if (wr_en) begin
         if (wr_addr != 5'd0) mem_a[wr_addr] = wr_data;
         mem_b[wr_addr] = wr_data;
      end
   endtask

   // Drive one cycle, check every output at the falling edge, advance the model.
   task automatic cycle(input logic r, input logic we, input int wa, input logic [31:0] wd,
                        input logic [19:0] ra);
      reset    = r;
      wr_en    = we;
      wr_addr  = 5'(wa);
      wr_data  = wd;
      rd_addr4 = ra;
      @(negedge clock);
      s_busy = busy4;
      s_rd4  = rd_data4;
      s_rd2  = rd_data2;
      if (m_known) begin
         check("busy_a", {31'b0, busy4}, {31'b0, m_busy});
         check("busy_b", {31'b0, busy2}, {31'b0, m_busy});
         for (int i = 0; i < 4; i++)
            check($sformatf("a_rd%0d", i), rd_data4[i*32 +: 32], exp_rd(1'b1, ra[i*5 +: 5]));
         for (int i = 0; i < 2; i++)
            check($sformatf("b_rd%0d", i), rd_data2[i*32 +: 32], exp_rd(1'b0, ra[i*5 +: 5]));
      end
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic sweep_len(input string tag, input int mid_reset_at);
      int n;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == mid_reset_at) begin
            cycle(1'b1, 1'b0, 0, 32'h0, '0);
            n = 0;
         end else begin
            cycle(1'b0, (i == 5), 3, 32'hAA, pack(3, 3, i % 32, 0));
            if (s_busy) n++;
            else break;
         end
      end
      check(tag, 32'(n), 32'd32);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr4 = '0;

      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0, 32'h0, '0);
      check("rst_busy", {31'b0, s_busy}, 32'd1);
      check("rst_rd0", s_rd4[31:0], 32'h0);

      sweep_len("sweep_len", -1);

      for (int a = 0; a < DEPTH; a++) begin
         cycle(1'b0, 1'b0, 0, 32'h0, pack(a, (a + 1) % 32, (a + 2) % 32, (a + 3) % 32));
         if (a == 3) check("r3_after_busy", s_rd4[31:0], 32'h0);
      end

      cycle(1'b0, 1'b1, 1, 32'd12, '0);
      cycle(1'b0, 1'b1, 2, 32'd43, '0);
      cycle(1'b0, 1'b0, 0, 32'h0, pack(1, 2, 0, 0));
      check("basic_r1", s_rd4[31:0], 32'd12);
      check("basic_r2", s_rd4[63:32], 32'd43);

      cycle(1'b0, 1'b1, 0, 32'hDEADBEEF, pack(0, 0, 0, 0));
      check("zero_wcyc", s_rd4[127:96], 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0, pack(0, 0, 0, 0));
      check("zero_after", s_rd4[31:0], 32'h0);
      check("nozero_b", s_rd2[31:0], 32'hDEADBEEF);

      cycle(1'b0, 1'b1, 7, 32'h55, pack(1, 7, 7, 2));
      check("byp_a", s_rd4[63:32], 32'h55);
      check("nobyp_b", s_rd2[63:32], 32'h0);
      cycle(1'b0, 1'b0, 0, 32'h0, pack(1, 7, 0, 0));
      check("nobyp_b_next", s_rd2[63:32], 32'h55);

      for (int i = 10; i < 14; i++) cycle(1'b0, 1'b1, i, 32'h100 + 32'(i), '0);
      cycle(1'b0, 1'b0, 0, 32'h0, pack(10, 11, 12, 13));
      check("p4_r10", s_rd4[31:0], 32'h10A);
      check("p4_r13", s_rd4[127:96], 32'h10D);

      cycle(1'b1, 1'b0, 0, 32'h0, '0);
      sweep_len("midrst_len", 10);
      cycle(1'b0, 1'b0, 0, 32'h0, pack(1, 2, 7, 10));
      check("cleared_r7", s_rd4[95:64], 32'h0);

      for (int i = 0; i < 600; i++) begin
         logic [4:0]  wa;
         logic [19:0] ra;
         wa = 5'($urandom_range(0, 31));
         ra = 20'($urandom);
         if ($urandom_range(0, 3) == 0) ra[9:5] = wa;
         if ($urandom_range(0, 7) == 0) ra[4:0] = wa;
         cycle(($urandom_range(0, 199) == 0), 1'($urandom), 32'(wa), 32'($urandom), ra);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS32 datapath, the successor to the fixed 32x32 two-read/one-write file. It adds a configurable read-port count, a hardwired-zero register, optional same-cycle write-to-read bypass, and a synchronous reset with a hardware clear sweep. While the sweep runs it reports `busy`. It sits between decode (read addresses) and writeback (write port). Register contents are cleared by hardware, not preloaded by simulation initialisers.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth DEPTH = 2**ADDR_W.
- `NUM_RD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: when 1, register 0 always reads 0 and ignores writes.
- `BYPASS`, 1: when 1, a write in the current cycle is visible on a matching read port in that same cycle.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; restarts the clear sweep.
- `rd_addr`  in  NUM_RD*ADDR_W: read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W: read data; port i uses bits [i*DATA_W +: DATA_W]; combinational.
- `wr_en`  in  1: write enable (RegWrite).
- `wr_addr`  in  ADDR_W: write address.
- `wr_data`  in  DATA_W: write data.
- `busy`  out  1: registered; high while the clear sweep is in progress.

## Operation
- State machine with two states:
  - CLEAR: entered on any clock edge where `reset`=1; the clear counter `clr_cnt` is set to 0.
  - CLEAR sweep: each edge with `reset`=0 writes RF[clr_cnt]=0 and increments `clr_cnt`. The edge that clears index DEPTH-1 moves to READY.
  - READY: normal operation; stays in READY until `reset` is asserted.
- `busy` = (state == CLEAR). It is 1 from the first reset edge and stays 1 through DEPTH edges after `reset` deasserts.
- Writes: in READY, when `wr_en`=1, RF[wr_addr] <= wr_data on the edge. If ZERO_REG=1 and wr_addr=0, the write is dropped. In CLEAR, `wr_en` is ignored entirely.
- Reads (per port, combinational), applied in priority order:
  1. busy=1 -> 0.
  2. ZERO_REG=1 and rd_addr=0 -> 0.
  3. BYPASS=1, wr_en=1 and wr_addr==rd_addr -> wr_data.
  4. Otherwise -> RF[rd_addr].
- Multiple ports may read the same address in the same cycle; each gets an identical result.
- Write and sweep are exclusive by state, so there is no write-port contention.
- Reset mid-sweep: `clr_cnt` returns to 0 and the sweep restarts; DEPTH edges are needed after the final deassertion.
- Reset in READY: the register contents are cleared again by a new sweep.
- Register array contents before the first reset are don't-care. Outputs are masked to 0 while busy=1.

## Timing
- Read latency is 0 cycles (address to data, combinational).
- Write latency is 1 edge. With BYPASS=0, the written value is visible on reads in the cycle after the write edge. With BYPASS=1, it is also visible in the write cycle itself.
- Reset values: `busy`=1, state=CLEAR, `clr_cnt`=0, every `rd_data` lane=0.
- Sweep length is exactly DEPTH cycles; for ADDR_W=5 that is 32 cycles, with `busy` falling on the 32nd edge after `reset` deasserts.
- `clr_cnt` is ADDR_W+1 bits wide; the terminal compare is against DEPTH-1, and the counter never wraps.
- There is no combinational path from `wr_*` to `busy`. The only combinational path from `wr_*` to `rd_data` is the bypass path.

## Structure
- Package `regfile_pkg` holds:
  - default localparams: DATA_W=32, ADDR_W=5, NUM_RD=2;
  - the state enum `rf_state_t` {RF_CLEAR, RF_READY}.
- Sub-module `regfile_read_port` implements one read lane (zero mask, bypass compare, array mux). It is instantiated NUM_RD times in a generate loop.
- The top level owns the storage array, the write logic, the FSM and the clear counter.

## Test plan
- Reset, then sweep: assert `reset` for 3 cycles, then release -> `busy`=1 for exactly 32 edges; every address then reads 0; `busy`=0 from the 33rd cycle on.
- Basic write/read: write 12 to r1 and 43 to r2, then read rd_addr0=1, rd_addr1=2 -> rd_data lanes 12 and 43.
- Zero register: write 0xDEADBEEF to r0 -> r0 reads 0 on all ports, including in the write cycle with BYPASS=1.
- Bypass: BYPASS=1, same-cycle write of 0x55 to r7 while port1 reads r7 -> port1 shows 0x55 in that cycle. With BYPASS=0 it shows the old value, then 0x55 the next cycle.
- Write during busy: pulse `wr_en` to r3 with 0xAA during the sweep -> after `busy` falls, r3 reads 0.
- Reset mid-sweep: assert `reset` at sweep cycle 10 for 1 cycle -> `busy` stays high and falls 32 edges after the release; NUM_RD=4 build reads 4 different registers correctly in one cycle.
